prga_decoder: RTL and testbench

PRGA_DECODER -- requirements
Module: prga_decoder

---
 rtl/prga_pkg.sv | 24 ++
 rtl/prga_decoder.sv | 176 +++++++++++++++++
 tb/tb_prga_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/prga_pkg.sv
// Shared widths, defaults and state encoding for the RC4 PRGA decoder.
package prga_pkg;

  localparam int MSG_LEN_DEF = 32;
  localparam int S_AW        = 8;
  localparam int DATA_W      = 8;
  localparam int MSG_AW      = 5;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INC_I  = 4'd1,
    RD_SI  = 4'd2,
    WT_SI  = 4'd3,
    RD_SJ  = 4'd4,
    WT_SJ  = 4'd5,
    WR_SI  = 4'd6,
    WR_SJ  = 4'd7,
    RD_F   = 4'd8,
    WT_F   = 4'd9,
    WR_OUT = 4'd10,
    DONE   = 4'd11
  } prga_state_e;

endpackage

// File: rtl/prga_decoder.sv
// RC4 PRGA stage: walks the S memory left by the KSA, swaps entries and
// XORs the keystream with the encrypted ROM into the decrypted RAM.
module prga_decoder
  import prga_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              complete,
  output logic [S_AW-1:0]   s_address,
  output logic [DATA_W-1:0] s_data,
  output logic              s_wren,
  input  logic [DATA_W-1:0] s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [MSG_AW-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  prga_state_e       state_r, state_nxt_s;
  logic [S_AW-1:0]   i_r, i_nxt_s, j_r, j_nxt_s;
  logic [MSG_AW-1:0] k_r, k_nxt_s;
  logic [DATA_W-1:0] si_r, si_nxt_s, sj_r, sj_nxt_s;
  logic [DATA_W-1:0] f_r, f_nxt_s, enc_r, enc_nxt_s;

  logic              complete_s, s_wren_s, ram_wren_s;
  logic [S_AW-1:0]   s_address_s;
  logic [DATA_W-1:0] s_data_s, ram_data_s;
  logic [MSG_AW-1:0] rom_address_s, ram_address_s;

  // Next-state and datapath register updates
  always_comb begin
    state_nxt_s = state_r;
    i_nxt_s     = i_r;
    j_nxt_s     = j_r;
    k_nxt_s     = k_r;
    si_nxt_s    = si_r;
    sj_nxt_s    = sj_r;
    f_nxt_s     = f_r;
    enc_nxt_s   = enc_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          i_nxt_s     = 8'd0;
          j_nxt_s     = 8'd0;
          k_nxt_s     = 5'd0;
          state_nxt_s = INC_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INC_I: begin
        i_nxt_s     = i_r + 8'd1;
        state_nxt_s = RD_SI;
      end
      RD_SI: state_nxt_s = WT_SI;
      WT_SI: begin
        si_nxt_s    = s_q;
        enc_nxt_s   = rom_q;
        j_nxt_s     = j_r + s_q;
        state_nxt_s = RD_SJ;
      end
      RD_SJ: state_nxt_s = WT_SJ;
      WT_SJ: begin
        sj_nxt_s    = s_q;
        state_nxt_s = WR_SI;
      end
      WR_SI: state_nxt_s = WR_SJ;
      WR_SJ: state_nxt_s = RD_F;
      RD_F:  state_nxt_s = WT_F;
      WT_F: begin
        f_nxt_s     = s_q;
        state_nxt_s = WR_OUT;
      end
      WR_OUT: begin
        if (k_r == K_LAST) begin
          state_nxt_s = DONE;
        end else begin
          k_nxt_s     = k_r + 5'd1;
          state_nxt_s = INC_I;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    complete_s    = 1'b0;
    s_address_s   = 8'd0;
    s_data_s      = 8'd0;
    s_wren_s      = 1'b0;
    rom_address_s = 5'd0;
    ram_address_s = 5'd0;
    ram_data_s    = 8'd0;
    ram_wren_s    = 1'b0;
    case (state_nxt_s)
      RD_SI: begin
        s_address_s   = i_nxt_s;
        rom_address_s = k_nxt_s;
      end
      RD_SJ: s_address_s = j_nxt_s;
      WR_SI: begin
        s_address_s = i_nxt_s;
        s_data_s    = sj_nxt_s;
        s_wren_s    = 1'b1;
      end
      WR_SJ: begin
        s_address_s = j_nxt_s;
        s_data_s    = si_nxt_s;
        s_wren_s    = 1'b1;
      end
      RD_F: s_address_s = si_nxt_s + sj_nxt_s;
      WR_OUT: begin
        ram_address_s = k_nxt_s;
        ram_data_s    = f_nxt_s ^ enc_nxt_s;
        ram_wren_s    = 1'b1;
      end
      DONE: complete_s = 1'b1;
      default: complete_s = 1'b0;
    endcase
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      i_r         <= 8'd0;
      j_r         <= 8'd0;
      k_r         <= 5'd0;
      si_r        <= 8'd0;
      sj_r        <= 8'd0;
      f_r         <= 8'd0;
      enc_r       <= 8'd0;
      complete    <= 1'b0;
      s_address   <= 8'd0;
      s_data      <= 8'd0;
      s_wren      <= 1'b0;
      rom_address <= 5'd0;
      ram_address <= 5'd0;
      ram_data    <= 8'd0;
      ram_wren    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      i_r         <= i_nxt_s;
      j_r         <= j_nxt_s;
      k_r         <= k_nxt_s;
      si_r        <= si_nxt_s;
      sj_r        <= sj_nxt_s;
      f_r         <= f_nxt_s;
      enc_r       <= enc_nxt_s;
      complete    <= complete_s;
      s_address   <= s_address_s;
      s_data      <= s_data_s;
      s_wren      <= s_wren_s;
      rom_address <= rom_address_s;
      ram_address <= ram_address_s;
      ram_data    <= ram_data_s;
      ram_wren    <= ram_wren_s;
    end
  end

endmodule

// File: tb/tb_prga_decoder.sv
// Directed and model-checked bench for prga_decoder with behavioural
// S memory, encrypted ROM and decrypted RAM (1-cycle read latency).
module tb_prga_decoder;

  logic       clk = 1'b0;
  logic       reset, start, complete;
  logic [7:0] s_address, s_data, s_q, rom_q, ram_data;
  logic       s_wren, ram_wren;
  logic [4:0] rom_address, ram_address;

  logic [7:0] s_mem [256];
  logic [7:0] rom_mem [32];
  logic [7:0] ram_mem [32];
  logic [7:0] m_s [256];
  logic [7:0] exp_dec [32];

  int checks = 0;
  int failures = 0;
  int s_pulses, ram_pulses, edges;

  typedef struct {
    string       name;
    logic [35:0] exp;  // {s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren}
  } vec_t;
  vec_t vecs [12];

  prga_decoder #(.MSG_LEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .complete(complete),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren)
  );

  always #5 clk = ~clk;

  // Synchronous memories: read data appears the cycle after the address
  always @(posedge clk) begin
    if (s_wren) s_mem[s_address] <= s_data;
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    s_q   <= s_mem[s_address];
    rom_q <= rom_mem[rom_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    if (s_wren) s_pulses++;
    if (ram_wren) ram_pulses++;
    @(posedge clk);
    #1;
  endtask

  task automatic init_identity();
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    for (int x = 0; x < 32; x++) begin
      rom_mem[x] = 8'h00;
      ram_mem[x] = 8'h00;
    end
  endtask

  // Textbook RC4 PRGA over a snapshot of the S memory and the ROM
  task automatic model_run();
    logic [7:0] i, j, t;
    for (int x = 0; x < 256; x++) m_s[x] = s_mem[x];
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      exp_dec[k] = m_s[8'(m_s[i] + m_s[j])] ^ rom_mem[k];
    end
  endtask

  task automatic run_full();
    s_pulses = 0;
    ram_pulses = 0;
    start = 1'b1;
    edges = 0;
    while (!complete && edges < 400) begin
      step();
      edges++;
    end
    start = 1'b0;
    step();
  endtask

  task automatic check_result(input string tag);
    for (int k = 0; k < 32; k++) check($sformatf("%s_dec%0d", tag, k), ram_mem[k], exp_dec[k]);
    for (int x = 0; x < 256; x++)
      if (s_mem[x] !== m_s[x]) check($sformatf("%s_s%0d", tag, x), s_mem[x], m_s[x]);
  endtask

  initial begin
    // First byte and start of second byte, identity S, zero ciphertext
    vecs[0]  = '{"c1_inc_i",  {8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[1]  = '{"c2_rd_si",  {8'h01, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[2]  = '{"c3_wt_si",  {8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[3]  = '{"c4_rd_sj",  {8'h01, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[4]  = '{"c5_wt_sj",  {8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[5]  = '{"c6_wr_si",  {8'h01, 8'h01, 1'b1, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[6]  = '{"c7_wr_sj",  {8'h01, 8'h01, 1'b1, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[7]  = '{"c8_rd_f",   {8'h02, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[8]  = '{"c9_wt_f",   {8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[9]  = '{"c10_wr_out",{8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 8'h02, 1'b1}};
    vecs[10] = '{"c11_inc_i", {8'h00, 8'h00, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0}};
    vecs[11] = '{"c12_rd_si", {8'h02, 8'h00, 1'b0, 5'd1, 5'd0, 8'h00, 1'b0}};

    reset = 1'b1;
    start = 1'b0;
    init_identity();
    step();
    step();
    check("rst_complete", complete, 1'b0);
    check("rst_wren", {s_wren, ram_wren}, 2'b00);
    check("rst_addr", {s_address, rom_address, ram_address, s_data, ram_data}, 34'h0);
    reset = 1'b0;
    step();
    check("idle_no_start", complete, 1'b0);

    // Identity S: cycle table, complete timing and hold/fall
    model_run();
    start = 1'b1;
    edges = 0;
    for (int r = 0; r < 12; r++) begin
      step();
      edges++;
      check(vecs[r].name, {s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren},
            vecs[r].exp);
    end
    while (!complete && edges < 400) begin
      step();
      edges++;
      if (edges == 20) begin
        check("s1_after_i_eq_j", s_mem[1], 8'h01);
        check("s2_after_swap", s_mem[2], 8'h03);
        check("s3_after_swap", s_mem[3], 8'h02);
      end
    end
    check("complete_edge", edges, 321);
    for (int h = 0; h < 5; h++) begin
      step();
      check("complete_hold", complete, 1'b1);
    end
    start = 1'b0;
    step();
    check("complete_fall", complete, 1'b0);
    check("ident_dec0", ram_mem[0], 8'h02);
    check("ident_dec1", ram_mem[1], 8'h05);
    check_result("ident");

    // Modulo-256 wrap of j and of the f address
    init_identity();
    s_mem[8'h01] = 8'hF0;
    s_mem[8'hF0] = 8'h20;
    s_mem[8'h20] = 8'h01;
    rom_mem[0] = 8'hA5;
    model_run();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 4) check("wrap_j_addr", s_address, 8'hF0);
      if (c == 8) check("wrap_f_addr", s_address, 8'h10);
    end
    edges = 8;
    while (!complete && edges < 400) begin
      step();
      edges++;
    end
    check("wrap_complete_edge", edges, 321);
    start = 1'b0;
    step();
    check("wrap_dec0", ram_mem[0], 8'hB5);
    check_result("wrap");

    // Reset mid-run, then a clean rerun on the partly shuffled S
    init_identity();
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'($urandom_range(0, 255));
    start = 1'b1;
    for (int c = 0; c < 100; c++) step();
    reset = 1'b1;
    step();
    check("midrst_complete", complete, 1'b0);
    check("midrst_wren", {s_wren, ram_wren}, 2'b00);
    check("midrst_addr", {s_address, rom_address, ram_address}, 18'h0);
    reset = 1'b0;
    start = 1'b0;
    step();
    check("midrst_idle", {complete, s_wren, ram_wren}, 3'b000);
    for (int x = 0; x < 32; x++) ram_mem[x] = 8'h00;
    model_run();
    run_full();
    check("midrst_complete_edge", edges, 321);
    check_result("midrst");

    // Random permutation and ciphertext against the software model
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      int y;
      logic [7:0] t;
      y = int'($urandom_range(0, x));
      t = s_mem[x];
      s_mem[x] = s_mem[y];
      s_mem[y] = t;
    end
    for (int x = 0; x < 32; x++) begin
      rom_mem[x] = 8'($urandom_range(0, 255));
      ram_mem[x] = 8'h00;
    end
    model_run();
    run_full();
    check("rand_complete_edge", edges, 321);
    check("rand_ram_pulses", ram_pulses, 32);
    check("rand_s_pulses", s_pulses, 64);
    check_result("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
